// File: rtl/mips_mc_ctrl.sv
// Main control FSM for the lab4 multicycle MIPS datapath: decodes the IR opcode into register enables and mux/ALU selects.
// Optional bne support is compiled in when MIPS_MC_CTRL_BNE_EN is defined.
module mips_mc_ctrl #(
  parameter int USE_MEM_RDY = 1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_rdy,
  output logic               pcen,
  output logic               irwrite,
  output logic               regwrite,
  output logic               memwrite,
  output logic               iord,
  output logic               regdst,
  output logic               memtoreg,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsrc,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    BNE      = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t state_reg;
  state_t state_next;
  logic   rdy;
  logic   pcwrite;
  logic   branch;
  logic   branch_ne;

  // With handshaking disabled every memory access completes in its first cycle.
  assign rdy = (USE_MEM_RDY != 0) ? mem_rdy : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    illegal_op = 1'b0;
    pcen       = 1'b0;

    case (state_reg)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = rdy;
        pcwrite = rdy;
        if (rdy) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEXEC;
          OP_J:         state_next = JUMP;
`ifdef MIPS_MC_CTRL_BNE_EN
          OP_BNE:       state_next = BNE;
`endif
          default: begin
            illegal_op = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        if (rdy) begin
          state_next = MEMWB;
        end
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        // Strobe held for the whole access so slow memory sees a stable request.
        iord     = 1'b1;
        memwrite = 1'b1;
        if (rdy) begin
          state_next = FETCH;
        end
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        aluop      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        state_next = FETCH;
      end
      ADDIEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        regwrite   = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        state_next = FETCH;
      end
`ifdef MIPS_MC_CTRL_BNE_EN
      BNE: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch_ne  = 1'b1;
        state_next = FETCH;
      end
`endif
      default: begin
        state_next = FETCH;
      end
    endcase

    pcen = pcwrite | (branch & zero) | (branch_ne & ~zero);

    // Reset forces every strobe and select low in the same cycle, not just the next one.
    if (reset) begin
      state_next = FETCH;
      pcen       = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      illegal_op = 1'b0;
    end
  end

  assign state = STATE_W'(state_reg);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed self-checking bench for mips_mc_ctrl; honours MIPS_MC_CTRL_BNE_EN like the design.
module tb_mips_mc_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_rdy;
  logic       pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       illegal_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mips_mc_ctrl #(.USE_MEM_RDY(1), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_rdy(mem_rdy),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
    .iord(iord), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .illegal_op(illegal_op),
    .state(state)
  );

  // Field order: pcen irwrite regwrite memwrite iord regdst memtoreg alusrca alusrcb aluop pcsrc illegal_op
  logic [14:0] outv;
  assign outv = {pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg, alusrca,
                 alusrcb, aluop, pcsrc, illegal_op};

  localparam logic [14:0] V_ZERO = 15'b0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [14:0] V_F    = 15'b1_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [14:0] V_FW   = 15'b0_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [14:0] V_DEC  = 15'b0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [14:0] V_DILL = 15'b0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [14:0] V_MA   = 15'b0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [14:0] V_MRD  = 15'b0_0_0_0_1_0_0_0_00_00_00_0;
  localparam logic [14:0] V_MWB  = 15'b0_0_1_0_0_0_1_0_00_00_00_0;
  localparam logic [14:0] V_MWR  = 15'b0_0_0_1_1_0_0_0_00_00_00_0;
  localparam logic [14:0] V_EXE  = 15'b0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [14:0] V_AWB  = 15'b0_0_1_0_0_1_0_0_00_00_00_0;
  localparam logic [14:0] V_BR1  = 15'b1_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [14:0] V_BR0  = 15'b0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [14:0] V_AIE  = 15'b0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [14:0] V_AIW  = 15'b0_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [14:0] V_JMP  = 15'b1_0_0_0_0_0_0_0_00_00_10_0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_rdy = 1'b1; op = 6'b000000; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      checks++;
      if (outv !== V_ZERO) begin
        errors++;
        $display("FAIL reset_outs cyc%0d got %b exp %b", i, outv, V_ZERO);
      end
      checks++;
      if (state !== 4'd0) begin
        errors++;
        $display("FAIL reset_state cyc%0d got %0d exp 0", i, state);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (outv !== V_F) begin
      errors++;
      $display("FAIL reset_first_fetch got %b exp %b", outv, V_F);
    end
    mem_rdy = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    logic [3:0]  st[9]  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd0};
    logic [14:0] ev[9]  = '{V_FW, V_FW, V_F, V_DEC, V_MA, V_MRD, V_MRD, V_MWB, V_FW};
    logic        rd[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      // After MEMADR the opcode is scribbled; the sequence must not notice.
      op = (i >= 5) ? 6'b000000 : 6'b100011;
      mem_rdy = rd[i];
      #1;
      checks++;
      if (state !== st[i]) begin
        errors++;
        $display("FAIL lw_state cyc%0d got %0d exp %0d", i, state, st[i]);
      end
      checks++;
      if (outv !== ev[i]) begin
        errors++;
        $display("FAIL lw_outs cyc%0d got %b exp %b", i, outv, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_sw();
    logic [3:0]  st[8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    logic [14:0] ev[8] = '{V_F, V_DEC, V_MA, V_MWR, V_MWR, V_MWR, V_MWR, V_FW};
    logic        rd[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    op = 6'b101011;
    for (int i = 0; i < 8; i++) begin
      mem_rdy = rd[i];
      #1;
      checks++;
      if (state !== st[i]) begin
        errors++;
        $display("FAIL sw_state cyc%0d got %0d exp %0d", i, state, st[i]);
      end
      checks++;
      if (outv !== ev[i]) begin
        errors++;
        $display("FAIL sw_outs cyc%0d got %b exp %b", i, outv, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_alu_ops();
    logic [5:0]  ops[2]   = '{6'b000000, 6'b001000};
    logic [3:0]  st[2][5] = '{'{4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0}};
    logic [14:0] ev[2][5] = '{'{V_F, V_DEC, V_EXE, V_AWB, V_FW}, '{V_F, V_DEC, V_AIE, V_AIW, V_FW}};
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      for (int i = 0; i < 5; i++) begin
        mem_rdy = (i < 4);
        #1;
        checks++;
        if (state !== st[k][i]) begin
          errors++;
          $display("FAIL alu_state op%b cyc%0d got %0d exp %0d", ops[k], i, state, st[k][i]);
        end
        checks++;
        if (outv !== ev[k][i]) begin
          errors++;
          $display("FAIL alu_outs op%b cyc%0d got %b exp %b", ops[k], i, outv, ev[k][i]);
        end
        tick();
      end
    end
  endtask

  // Three-cycle instructions: beq taken/not taken, j, and (when enabled) bne.
  task automatic test_branch_jump();
    logic [5:0]  ops[5] = '{6'b000100, 6'b000100, 6'b000010, 6'b000101, 6'b000101};
    logic        zf[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef MIPS_MC_CTRL_BNE_EN
    logic [3:0]  s2[5]  = '{4'd8, 4'd8, 4'd11, 4'd12, 4'd12};
    logic [14:0] e2[5]  = '{V_BR1, V_BR0, V_JMP, V_BR1, V_BR0};
    logic [14:0] e1[5]  = '{V_DEC, V_DEC, V_DEC, V_DEC, V_DEC};
`else
    logic [3:0]  s2[5]  = '{4'd8, 4'd8, 4'd11, 4'd0, 4'd0};
    logic [14:0] e2[5]  = '{V_BR1, V_BR0, V_JMP, V_FW, V_FW};
    logic [14:0] e1[5]  = '{V_DEC, V_DEC, V_DEC, V_DILL, V_DILL};
`endif
    for (int k = 0; k < 5; k++) begin
      op = ops[k];
      zero = zf[k];
      for (int i = 0; i < 4; i++) begin
        logic [3:0]  es;
        logic [14:0] eo;
        es = (i == 1) ? 4'd1 : (i == 2) ? s2[k] : 4'd0;
        eo = (i == 0) ? V_F : (i == 1) ? e1[k] : (i == 2) ? e2[k] : V_FW;
        mem_rdy = (i == 0);
        if (!(i == 3 && s2[k] == 4'd0)) begin
          #1;
          checks++;
          if (state !== es) begin
            errors++;
            $display("FAIL br_state op%b z%0b cyc%0d got %0d exp %0d", ops[k], zf[k], i, state, es);
          end
          checks++;
          if (outv !== eo) begin
            errors++;
            $display("FAIL br_outs op%b z%0b cyc%0d got %b exp %b", ops[k], zf[k], i, outv, eo);
          end
          tick();
        end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    logic [3:0]  st[3] = '{4'd0, 4'd1, 4'd0};
    logic [14:0] ev[3] = '{V_F, V_DILL, V_FW};
    op = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      mem_rdy = (i == 0);
      #1;
      checks++;
      if (state !== st[i]) begin
        errors++;
        $display("FAIL illegal_state cyc%0d got %0d exp %0d", i, state, st[i]);
      end
      checks++;
      if (outv !== ev[i]) begin
        errors++;
        $display("FAIL illegal_outs cyc%0d got %b exp %b", i, outv, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    op = 6'b101011;
    for (int i = 0; i < 3; i++) begin
      mem_rdy = 1'b1;
      tick();
    end
    mem_rdy = 1'b0;
    #1;
    checks++;
    if (outv !== V_MWR || state !== 4'd5) begin
      errors++;
      $display("FAIL rstmid_wait got %b st%0d exp %b st5", outv, state, V_MWR);
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (outv !== V_ZERO) begin
      errors++;
      $display("FAIL rstmid_reset_cycle got %b exp %b", outv, V_ZERO);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || outv !== V_FW) begin
      errors++;
      $display("FAIL rstmid_after got st%0d %b exp st0 %b", state, outv, V_FW);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_alu_ops();
    test_branch_jump();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
